// File: rtl/apb_req_arbiter_if.sv
// Bundle of the requester-side command/response signals and the APB master bus.
// The arbiter connects through the master modport; requesters and the APB slave connect through the slave modport.
interface apb_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
);
    logic [1:0]          rq_valid;
    logic [1:0]          rq_write;
    logic [2*ADDR_W-1:0] rq_addr;
    logic [2*DATA_W-1:0] rq_wdata;
    logic [2*STRB_W-1:0] rq_strobe;
    logic [1:0]          rq_gnt;
    logic [1:0]          rq_done;
    logic [DATA_W-1:0]   rq_rdata;
    logic                rq_err;

    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [ADDR_W-1:0]   paddr;
    logic [DATA_W-1:0]   pwdata;
    logic [STRB_W-1:0]   pstrb;
    logic [DATA_W-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    modport master (
        input  rq_valid, rq_write, rq_addr, rq_wdata, rq_strobe,
        input  prdata, pready, pslverr,
        output rq_gnt, rq_done, rq_rdata, rq_err,
        output psel, penable, pwrite, paddr, pwdata, pstrb
    );

    modport slave (
        output rq_valid, rq_write, rq_addr, rq_wdata, rq_strobe,
        output prdata, pready, pslverr,
        input  rq_gnt, rq_done, rq_rdata, rq_err,
        input  psel, penable, pwrite, paddr, pwdata, pstrb
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter that turns level-held commands into APB transfers
// on one shared master port, with an optional ACCESS-phase timeout.
module apb_req_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = DATA_W / 8,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    apb_req_arbiter_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t            state;
    state_t            state_nxt;
    logic              owner;
    logic              last_gnt;
    logic              winner;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        gnt;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [STRB_W-1:0] pstrb_q;
    logic              pready_hit;
    logic              timeout_hit;
    logic              finish;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latch).
        state_nxt   = state;
        winner      = 1'b0;
        pready_hit  = 1'b0;
        timeout_hit = 1'b0;

        // With both requesting, the one that did not complete last wins.
        if (bus.rq_valid == 2'b11)
            winner = ~last_gnt;
        else
            winner = bus.rq_valid[1];

        if (state == ACCESS) begin
            pready_hit  = bus.pready;
            timeout_hit = (TIMEOUT != 0) && !bus.pready && (cnt == CNT_LAST);
        end
        finish = pready_hit || timeout_hit;

        case (state)
            IDLE:    if (|bus.rq_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            cnt      <= '0;
            gnt      <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|bus.rq_valid) begin
                        owner    <= winner;
                        gnt      <= 2'b01 << winner;
                        pwrite_q <= bus.rq_write[winner];
                        paddr_q  <= bus.rq_addr[winner*ADDR_W +: ADDR_W];
                        pwdata_q <= bus.rq_wdata[winner*DATA_W +: DATA_W];
                        pstrb_q  <= bus.rq_strobe[winner*STRB_W +: STRB_W];
                    end
                end
                SETUP: cnt <= '0;
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (finish) begin
                        gnt      <= '0;
                        last_gnt <= owner;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.psel     = (state == SETUP) || (state == ACCESS);
    assign bus.penable  = (state == ACCESS);
    assign bus.pwrite   = pwrite_q;
    assign bus.paddr    = paddr_q;
    assign bus.pwdata   = pwdata_q;
    assign bus.pstrb    = pstrb_q;
    assign bus.rq_gnt   = gnt;
    assign bus.rq_done  = finish ? (2'b01 << owner) : 2'b00;
    // Read data passes only on a real read completion; a timeout returns zero.
    assign bus.rq_rdata = (pready_hit && !pwrite_q) ? bus.prdata : '0;
    assign bus.rq_err   = pready_hit ? bus.pslverr : timeout_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt));
            assert ((bus.rq_done & ~gnt) == 2'b00);
            assert (!bus.penable || bus.psel);
        end
    end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with TIMEOUT=4: single write, wait-state read,
// contention, timeout, slave error and reset in the middle of a transfer.
module tb_apb_req_arbiter;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    apb_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        bus.rq_write[i]          = wr;
        bus.rq_addr[i*32 +: 32]  = a;
        bus.rq_wdata[i*32 +: 32] = d;
        bus.rq_strobe[i*4 +: 4]  = s;
    endtask

    initial begin
        rst           = 1'b1;
        bus.rq_valid  = '0;
        bus.rq_write  = '0;
        bus.rq_addr   = '0;
        bus.rq_wdata  = '0;
        bus.rq_strobe = '0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        // Reset state
        step();
        step();
        check("rst_psel",    bus.psel,     0);
        check("rst_penable", bus.penable,  0);
        check("rst_pwrite",  bus.pwrite,   0);
        check("rst_paddr",   bus.paddr,    0);
        check("rst_pwdata",  bus.pwdata,   0);
        check("rst_pstrb",   bus.pstrb,    0);
        check("rst_gnt",     bus.rq_gnt,   0);
        check("rst_done",    bus.rq_done,  0);
        check("rst_rdata",   bus.rq_rdata, 0);
        check("rst_err",     bus.rq_err,   0);
        rst = 1'b0;

        // Single write from requester 0, zero wait states
        set_cmd(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF);
        bus.pready   = 1'b1;
        bus.rq_valid = 2'b01;
        #1;
        check("t1_n_psel", bus.psel, 0);
        step();
        check("t1_n1_psel",    bus.psel,    1);
        check("t1_n1_penable", bus.penable, 0);
        check("t1_n1_gnt",     bus.rq_gnt,  2'b01);
        check("t1_n1_paddr",   bus.paddr,   32'h10);
        check("t1_n1_pwrite",  bus.pwrite,  1);
        check("t1_n1_pwdata",  bus.pwdata,  32'hA5A5_0001);
        check("t1_n1_pstrb",   bus.pstrb,   4'hF);
        check("t1_n1_done",    bus.rq_done, 0);
        step();
        check("t1_n2_penable", bus.penable,  1);
        check("t1_n2_done",    bus.rq_done,  2'b01);
        check("t1_n2_err",     bus.rq_err,   0);
        check("t1_n2_rdata",   bus.rq_rdata, 0);
        bus.rq_valid = 2'b00;
        step();
        check("t1_n3_psel", bus.psel,    0);
        check("t1_n3_gnt",  bus.rq_gnt,  0);
        check("t1_n3_done", bus.rq_done, 0);

        // Read from requester 1 with three wait states; pready wins on the timeout cycle
        set_cmd(1, 1'b0, 32'h20, 32'h0, 4'h0);
        bus.pready   = 1'b0;
        bus.rq_valid = 2'b10;
        step();
        check("t2_setup_gnt",    bus.rq_gnt, 2'b10);
        check("t2_setup_paddr",  bus.paddr,  32'h20);
        check("t2_setup_pwrite", bus.pwrite, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_wait_penable", bus.penable, 1);
            check("t2_wait_done",    bus.rq_done, 0);
            check("t2_wait_paddr",   bus.paddr,   32'h20);
        end
        step();
        bus.pready = 1'b1;
        bus.prdata = 32'h1234_5678;
        #1;
        check("t2_done",  bus.rq_done,  2'b10);
        check("t2_rdata", bus.rq_rdata, 32'h1234_5678);
        check("t2_err",   bus.rq_err,   0);
        check("t2_paddr", bus.paddr,    32'h20);
        bus.rq_valid = 2'b00;
        bus.pready   = 1'b0;
        step();
        check("t2_after_psel", bus.psel,    0);
        check("t2_after_done", bus.rq_done, 0);

        // Contention: last completion was requester 1, so order is 0,1,0,1
        set_cmd(0, 1'b1, 32'h100, 32'h1111_0000, 4'hF);
        set_cmd(1, 1'b1, 32'h200, 32'h2222_0000, 4'h3);
        bus.pready   = 1'b1;
        bus.rq_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t3_gnt",   bus.rq_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("t3_paddr", bus.paddr,  (k % 2 == 0) ? 32'h100 : 32'h200);
            step();
            check("t3_done",  bus.rq_done, (k % 2 == 0) ? 2'b01 : 2'b10);
            step();
            check("t3_idle_psel", bus.psel, 0);
        end

        // Timeout: requester 1 read, pready never comes
        set_cmd(1, 1'b0, 32'h30, 32'h0, 4'h0);
        bus.pready   = 1'b0;
        bus.prdata   = 32'hDEAD_BEEF;
        bus.rq_valid = 2'b10;
        step();
        check("t5_gnt", bus.rq_gnt, 2'b10);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_wait_done", bus.rq_done, 0);
        end
        step();
        check("t5_done",  bus.rq_done,  2'b10);
        check("t5_err",   bus.rq_err,   1);
        check("t5_rdata", bus.rq_rdata, 0);
        bus.rq_valid = 2'b00;
        step();
        check("t5_after_psel", bus.psel,   0);
        check("t5_after_gnt",  bus.rq_gnt, 0);

        // Slave error: requester 0 reads an out-of-range address
        set_cmd(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        bus.pready   = 1'b1;
        bus.pslverr  = 1'b1;
        bus.prdata   = 32'h0;
        bus.rq_valid = 2'b01;
        step();
        step();
        check("t4_done", bus.rq_done, 2'b01);
        check("t4_err",  bus.rq_err,  1);
        bus.rq_valid = 2'b00;
        bus.pslverr  = 1'b0;
        step();
        check("t4_after_psel", bus.psel, 0);

        // Reset during ACCESS; afterwards requester 0 must win contention
        set_cmd(1, 1'b1, 32'h40, 32'h4444_4444, 4'hF);
        bus.pready   = 1'b0;
        bus.rq_valid = 2'b10;
        step();
        check("t6_setup_gnt", bus.rq_gnt, 2'b10);
        step();
        check("t6_access_penable", bus.penable, 1);
        check("t6_access_done",    bus.rq_done, 0);
        rst = 1'b1;
        step();
        check("t6_rst_psel",    bus.psel,    0);
        check("t6_rst_penable", bus.penable, 0);
        check("t6_rst_gnt",     bus.rq_gnt,  0);
        check("t6_rst_done",    bus.rq_done, 0);
        check("t6_rst_paddr",   bus.paddr,   0);
        check("t6_rst_pwdata",  bus.pwdata,  0);
        rst = 1'b0;
        set_cmd(0, 1'b1, 32'h50, 32'h5555_5555, 4'hF);
        bus.rq_valid = 2'b11;
        step();
        check("t6_regrant_gnt",   bus.rq_gnt, 2'b01);
        check("t6_regrant_paddr", bus.paddr,  32'h50);
        bus.pready = 1'b1;
        step();
        check("t6_regrant_done", bus.rq_done, 2'b01);
        bus.rq_valid = 2'b00;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
